shiftreg_rw_ctrl: RTL and testbench
===================================

SHIFTREG_RW_CTRL -- requirements
Module: shiftreg_rw_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: number of bits shifted per transaction, legal range 2..256.
REQ-002 Parameter DIV, default 4: system-clock cycles per half period of sr_clk, legal range 1..255.
REQ-003 clk  input  1: system clock; all logic is on the rising edge of this clock.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 start  input  1: single-cycle transaction request, already synchronised to clk.
REQ-006 data_in  input  WIDTH: word to shift out, MSB first.
REQ-007 sr_din  input  1: serial readback from the external shift register.
REQ-008 sr_clk  output  1: shift clock to the external register.
REQ-009 sr_dout  output  1: serial data to the external register.
REQ-010 sr_load  output  1: parallel-load strobe to the external register.
REQ-011 busy  output  1: high while a transaction is in progress.
REQ-012 done  output  1: one-cycle pulse at transaction end.
REQ-013 data_out  output  WIDTH: captured readback word; valid from the done pulse and held until the next done.

Function
REQ-014 States SHALL be IDLE, SHIFT_LO, SHIFT_HI, LOAD and DONE; all outputs SHALL be registered.
REQ-015 IDLE with start=1 in cycle 0 SHALL latch data_in and enter SHIFT_LO in cycle 1 with bit index = WIDTH-1.
REQ-016 In SHIFT_LO, sr_clk SHALL be 0, sr_dout SHALL equal tx[index], and the state SHALL last exactly DIV cycles.
REQ-017 In SHIFT_HI, sr_clk SHALL be 1 for exactly DIV cycles; sr_din SHALL be sampled in the last SHIFT_HI cycle and shifted into the LSB of the rx register, with prior contents moving left.
REQ-018 At the end of SHIFT_HI: if index > 0, the block SHALL decrement index and return to SHIFT_LO; if index = 0, it SHALL enter LOAD.
REQ-019 In LOAD, sr_load SHALL be 1, sr_clk 0 and sr_dout 0, for exactly DIV cycles; the block SHALL then enter DONE.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle and data_out SHALL be updated from rx in the same cycle; the next state SHALL be IDLE.
REQ-021 Latency: with start in cycle 0, done SHALL be high in cycle 1 + 2*DIV*WIDTH + DIV.
REQ-022 busy SHALL be 1 from cycle 1 through the done cycle inclusive, and 0 in IDLE.
REQ-023 A start pulse while busy=1 SHALL be ignored, with no queuing and no effect on the current transaction.
REQ-024 A start pulse in the cycle after done SHALL be accepted normally, giving a back-to-back transaction.
REQ-025 A change to data_in after the start cycle SHALL NOT affect the transaction in progress.
REQ-026 The divider counter SHALL reload to DIV-1 on every state entry and SHALL count down to 0; there is no wrap-around beyond that.
REQ-027 In IDLE and DONE, sr_clk, sr_dout and sr_load SHALL all be 0.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, with sr_clk, sr_dout, sr_load, busy, done = 0, data_out = 0, and internal tx, rx, index and divider = 0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no done pulse; after reset release, the block SHALL wait for a new start.

Structure
REQ-030 The state encoding and the sr_clk idle level (0) SHALL be defined in the shared package shiftreg_pkg.
REQ-031 The half-period divider SHALL be a sub-module sr_tick_gen (clk, rst_n, reload, tick) parameterised by DIV.
REQ-032 The datapath (tx, rx, index) and the FSM SHALL reside in shiftreg_rw_ctrl; no other sub-modules are used.

Verification
REQ-033 WIDTH=8, DIV=2, data_in=0xA5, sr_din looped back from sr_dout -> sr_dout sequence 1,0,1,0,0,1,0,1; done in cycle 35; data_out=0xA5.
REQ-034 WIDTH=8, DIV=2, sr_din held at 1, data_in=0x00 -> data_out=0xFF; exactly 8 sr_clk rising edges; sr_load high for 2 cycles immediately before done.
REQ-035 A start pulse at cycle 10 during a transaction -> ignored: a single done in cycle 35 and busy low in cycle 36.
REQ-036 start in cycle 0, rst_n=0 in cycle 12 for 3 cycles -> all outputs 0 at once, no done pulse; a new start after release completes normally.
REQ-037 Back-to-back: start in the cycle after done with data_in=0x3C -> second done 35 cycles after that start; data_out=0x3C under loopback.
REQ-038 DIV=1, WIDTH=2, loopback, data_in=2'b10 -> done in cycle 6, data_out=2'b10, each sr_clk level lasting exactly 1 cycle.

Source files
------------

// File: rtl/shiftreg_pkg.sv
// Shared definitions for the serial shift-register read/write controller:
// FSM state encoding and the shift clock idle level.
package shiftreg_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LOAD     = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic SR_CLK_IDLE = 1'b0;

endpackage

// File: rtl/sr_tick_gen.sv
// Half-period timer: reloads to DIV-1 on request, counts down to 0 and holds;
// tick is high while the count sits at 0.
module sr_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic tick
);

  logic [7:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (reload) begin
      count_reg <= 8'(DIV - 1);
    end else if (count_reg != 8'd0) begin
      count_reg <= count_reg - 8'd1;
    end
  end

  assign tick = (count_reg == 8'd0);

endmodule

// File: rtl/shiftreg_rw_ctrl.sv
// Shifts a WIDTH-bit word out MSB first on sr_clk/sr_dout while capturing sr_din,
// then strobes sr_load and reports the captured word with a done pulse.
module shiftreg_rw_ctrl
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             sr_din,
  output logic             sr_clk,
  output logic             sr_dout,
  output logic             sr_load,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] tx_reg, tx_next;
  logic [WIDTH-1:0] rx_reg, rx_next;
  logic [IW-1:0]    index_reg, index_next;
  logic             tick;
  logic             reload;
  logic             shifting_next;

  // Every state entry restarts the half-period timer.
  assign reload = (state_next != state_reg);

  sr_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .reload (reload),
    .tick   (tick)
  );

  always_comb begin
    state_next = state_reg;
    tx_next    = tx_reg;
    rx_next    = rx_reg;
    index_next = index_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SHIFT_LO;
          tx_next    = data_in;
          index_next = IW'(WIDTH - 1);
        end
      end
      SHIFT_LO: begin
        if (tick) state_next = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (tick) begin
          rx_next = {rx_reg[WIDTH-2:0], sr_din};
          if (index_reg != '0) begin
            index_next = index_reg - 1'b1;
            state_next = SHIFT_LO;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (tick) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  assign shifting_next = (state_next == SHIFT_LO) || (state_next == SHIFT_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      tx_reg    <= '0;
      rx_reg    <= '0;
      index_reg <= '0;
      sr_clk    <= SR_CLK_IDLE;
      sr_dout   <= 1'b0;
      sr_load   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      data_out  <= '0;
    end else begin
      state_reg <= state_next;
      tx_reg    <= tx_next;
      rx_reg    <= rx_next;
      index_reg <= index_next;
      sr_clk    <= (state_next == SHIFT_HI) ? 1'b1 : SR_CLK_IDLE;
      sr_dout   <= shifting_next ? tx_next[index_next] : 1'b0;
      sr_load   <= (state_next == LOAD);
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
      if (state_next == DONE) data_out <= rx_next;
    end
  end

endmodule

// File: tb/tb_shiftreg_rw_ctrl.sv
// Randomised and directed checks of shiftreg_rw_ctrl against a cycle-offset
// behavioural model, plus a small WIDTH=2/DIV=1 instance with literal checks.
module tb_shiftreg_rw_ctrl;

  localparam int W      = 8;
  localparam int D      = 2;
  localparam int NBIT   = 2 * D * W;
  localparam int DONE_K = NBIT + D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sr_din = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         sr_clk, sr_dout, sr_load, busy, done;
  logic [W-1:0] data_out;

  logic         start2 = 1'b0;
  logic [1:0]   data2 = 2'b00;
  logic         sr_din2;
  logic         sr_clk2, sr_dout2, sr_load2, busy2, done2;
  logic [1:0]   data_out2;

  always #5 clk = ~clk;

  shiftreg_rw_ctrl #(.WIDTH(W), .DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .sr_din(sr_din),
    .sr_clk(sr_clk), .sr_dout(sr_dout), .sr_load(sr_load), .busy(busy),
    .done(done), .data_out(data_out)
  );

  assign sr_din2 = sr_dout2;

  shiftreg_rw_ctrl #(.WIDTH(2), .DIV(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start2), .data_in(data2), .sr_din(sr_din2),
    .sr_clk(sr_clk2), .sr_dout(sr_dout2), .sr_load(sr_load2), .busy(busy2),
    .done(done2), .data_out(data_out2)
  );

  int errors = 0;
  int checks = 0;

  // Model: m_k is the offset of the current cycle from the first shifting cycle.
  bit           m_active = 1'b0;
  int           m_k = 0;
  logic [W-1:0] m_tx = '0;
  logic [W-1:0] m_rx = '0;
  logic [W-1:0] m_word = '0;

  int           din_mode = 0;  // 0 loopback, 1 held high, 2 random
  int           cyc = 0;
  int           done_cnt = 0;
  int           last_done_cyc = -1;
  int           rises = 0;
  int           load_streak = 0;
  int           load_before_done = 0;
  logic         prev_clk = 1'b0;
  logic [W-1:0] rise_bits = '0;
  int           t0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: compare outputs to the model, drive inputs, advance the model.
  task automatic step(input logic st, input logic [W-1:0] d, input logic rn);
    logic e_clk, e_dout, e_load, e_busy, e_done;
    @(negedge clk);
    e_clk = 1'b0; e_dout = 1'b0; e_load = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (m_active) begin
      e_busy = 1'b1;
      if (m_k < NBIT) begin
        e_clk  = (m_k % (2 * D)) >= D;
        e_dout = m_tx[W - 1 - m_k / (2 * D)];
      end else if (m_k < DONE_K) begin
        e_load = 1'b1;
      end else begin
        e_done = 1'b1;
      end
    end
    chk1("sr_clk", sr_clk, e_clk);
    chk1("sr_dout", sr_dout, e_dout);
    chk1("sr_load", sr_load, e_load);
    chk1("busy", busy, e_busy);
    chk1("done", done, e_done);
    chkw("data_out", data_out, m_word);

    if (sr_clk && !prev_clk) begin
      rises++;
      rise_bits = {rise_bits[W-2:0], sr_dout};
    end
    prev_clk = sr_clk;
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
      load_before_done = load_streak;
    end
    if (sr_load) load_streak++;
    else load_streak = 0;

    start   = st;
    data_in = d;
    rst_n   = rn;
    case (din_mode)
      0:       sr_din = sr_dout;
      1:       sr_din = 1'b1;
      default: sr_din = 1'($urandom_range(0, 1));
    endcase

    if (!rn) begin
      m_active = 1'b0;
      m_k      = 0;
      m_rx     = '0;
      m_word   = '0;
    end else if (m_active) begin
      if (m_k < NBIT && (m_k % (2 * D)) == 2 * D - 1) m_rx = {m_rx[W-2:0], sr_din};
      if (m_k == DONE_K) begin
        m_active = 1'b0;
      end else begin
        m_k++;
        if (m_k == DONE_K) m_word = m_rx;
      end
    end else if (st) begin
      m_active = 1'b1;
      m_k      = 0;
      m_tx     = d;
    end
    cyc++;
  endtask

  task automatic clear_obs();
    done_cnt = 0; rises = 0; rise_bits = '0; load_before_done = 0;
  endtask

  initial begin
    din_mode = 0;
    repeat (3) step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    chkw("reset_data_out", data_out, '0);
    chk1("reset_busy", busy, 1'b0);

    // A5 under loopback, data_in scrambled after the start cycle
    clear_obs();
    t0 = cyc;
    step(1'b1, 8'hA5, 1'b1);
    repeat (36) step(1'b0, W'($urandom), 1'b1);
    chki("a5_done_cycle", last_done_cyc - t0, 35);
    chki("a5_done_count", done_cnt, 1);
    chkw("a5_data_out", data_out, 8'hA5);
    chkw("a5_dout_seq", rise_bits, 8'hA5);
    chki("a5_rises", rises, 8);

    // sr_din held high, zero data
    din_mode = 1;
    clear_obs();
    t0 = cyc;
    step(1'b1, 8'h00, 1'b1);
    repeat (36) step(1'b0, 8'h00, 1'b1);
    chkw("ones_data_out", data_out, 8'hFF);
    chki("ones_rises", rises, 8);
    chki("ones_load_len", load_before_done, 2);
    chki("ones_done_cycle", last_done_cyc - t0, 35);

    // back-to-back: start on the cycle after done
    din_mode = 0;
    clear_obs();
    step(1'b1, 8'h11, 1'b1);
    repeat (35) step(1'b0, 8'h00, 1'b1);
    t0 = cyc;
    step(1'b1, 8'h3C, 1'b1);
    repeat (36) step(1'b0, 8'h00, 1'b1);
    chki("b2b_done_count", done_cnt, 2);
    chki("b2b_done_cycle", last_done_cyc - t0, 35);
    chkw("b2b_data_out", data_out, 8'h3C);

    // start pulse while busy is ignored
    din_mode = 2;
    clear_obs();
    t0 = cyc;
    step(1'b1, W'($urandom), 1'b1);
    repeat (9) step(1'b0, W'($urandom), 1'b1);
    step(1'b1, W'($urandom), 1'b1);
    repeat (26) step(1'b0, W'($urandom), 1'b1);
    chki("ign_done_count", done_cnt, 1);
    chki("ign_done_cycle", last_done_cyc - t0, 35);

    // reset mid-transaction aborts it
    din_mode = 0;
    clear_obs();
    step(1'b1, 8'h5A, 1'b1);
    repeat (11) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    #1;
    chk1("rst_now_busy", busy, 1'b0);
    chk1("rst_now_sr_clk", sr_clk, 1'b0);
    chk1("rst_now_sr_dout", sr_dout, 1'b0);
    chk1("rst_now_sr_load", sr_load, 1'b0);
    chk1("rst_now_done", done, 1'b0);
    chkw("rst_now_data_out", data_out, '0);
    repeat (2) step(1'b0, 8'h00, 1'b0);
    repeat (30) step(1'b0, 8'h00, 1'b1);
    chki("rst_no_done", done_cnt, 0);
    step(1'b1, 8'hC3, 1'b1);
    repeat (36) step(1'b0, 8'h00, 1'b1);
    chki("rst_new_done", done_cnt, 1);
    chkw("rst_new_data_out", data_out, 8'hC3);

    // randomised traffic with stray starts
    din_mode = 2;
    for (int t = 0; t < 6; t++) begin
      step(1'b1, W'($urandom), 1'b1);
      for (int c = 0; c < 40; c++) step(($urandom_range(0, 7) == 0), W'($urandom), 1'b1);
    end
    step(1'b0, 8'h00, 1'b1);
    repeat (40) step(1'b0, 8'h00, 1'b1);

    // WIDTH=2, DIV=1 instance under loopback
    @(negedge clk);
    start2 = 1'b1;
    data2  = 2'b10;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      start2 = 1'b0;
      data2  = 2'b01;
      chk1("small_sr_clk", sr_clk2, (n == 2 || n == 4));
      chk1("small_sr_dout", sr_dout2, (n <= 2));
      chk1("small_sr_load", sr_load2, (n == 5));
      chk1("small_done", done2, (n == 6));
      chk1("small_busy", busy2, (n <= 6));
      if (n >= 6) chkw("small_data_out", W'(data_out2), W'(2'b10));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
